rr_channel_arbiter: RTL and testbench
=====================================

Name: rr_channel_arbiter

Overview:
Round-robin arbiter that shares one registered 4-bit output channel among four requesters. Each requester presents a data word on b0..b3 and raises its req bit. The block grants the channel to one requester at a time, for at most HOLD cycles, and drives the registered output c from the granted source. It also drives the channel select code in the 3-bit format already used by our registered channel mux: 000..011 selects source 0..3, and 100 means idle / zero.

Parameters:
HOLD, 4, maximum grant length in cycles; legal range 1..15; grant counter is 4 bits.
W, 4, data width of b0..b3 and c.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-low reset; sampled on the rising clk edge.
req  input  4  request per source; bit i belongs to source i.
done  input  4  early release; bit i is honoured only while source i holds the grant.
b0  input  W  data of source 0.
b1  input  W  data of source 1.
b2  input  W  data of source 2.
b3  input  W  data of source 3.
grant  output  4  one-hot current owner; 0000 when idle.
sel  output  3  select code: 000..011 = owner index; 100 = idle.
c  output  W  registered channel data.
valid  output  1  high when c carries data from a granted source.

Behaviour:
- Reset: when reset==0 at an edge: state=IDLE, grant=0000, sel=100, c=0, valid=0, cnt=0, RR pointer last=3 (source 0 gets first priority). Reset overrides all other inputs, including in the middle of a grant.
- FSM has two states, IDLE and GRANT. All outputs are registered.
- RR pick: scan indices last+1, last+2, last+3, last+4 (mod 4); choose the first index with req set. At every new grant, last := chosen index.
- IDLE:
  - If req!=0: go to GRANT; grant=onehot(pick); sel=pick; cnt=HOLD-1.
  - Otherwise stay in IDLE.
- GRANT, owner k. End of grant is evaluated at each edge and occurs if any of these holds: cnt==0, done[k]==1, req[k]==0.
  - End of grant with req!=0 (including req[k]): hand over back-to-back with no idle cycle. The new owner is picked starting at k+1. k is re-granted only if it is the sole requester; in that case cnt reloads to HOLD-1.
  - End of grant with req==0: go to IDLE; grant=0000; sel=100.
  - Otherwise: cnt decrements by 1 and the owner is unchanged.
- Grant length: an uninterrupted grant keeps grant high for exactly HOLD cycles. The cycle in which done[k] is high, or req[k] is low, is the last grant cycle.
- done bits of non-owners are ignored. req changes for non-owners only affect the next pick.
- Data path, one-cycle latency after grant:
  - At each edge where state==GRANT (before the update): c <= b[sel], valid <= 1.
  - At each edge where state==IDLE: c <= 0, valid <= 0.
  - Hence c and valid lag grant and sel by exactly one cycle. On a handover edge, c captures the outgoing owner's data.
- Latency: req first sampled at edge E0 -> grant and sel valid after E0 -> c = b[owner] and valid=1 after E1.
- Invariants:
  - grant is one-hot or zero.
  - sel is never 101..111.
  - sel==100 if and only if grant==0000.
  - No source is starved while it keeps req high: worst-case wait is 3*HOLD cycles.

Test Plan:
- Reset: hold reset=0 for 3 edges with req=1111 and b0=5 -> grant=0000, sel=100, c=0, valid=0. Release reset -> grant=0001 after the next edge.
- Single source: HOLD=4, req=0010, b1=4'hA -> grant=0010 and sel=001 after E0; c=A and valid=1 from E1 onward. After 4 cycles source 1 is re-granted with no gap, and grant stays high continuously.
- Full contention: HOLD=4, req=1111, b0..b3=1,2,3,4 -> grant sequence 0001, 0010, 0100, 1000, 0001, 4 cycles each. c sequence 1,2,3,4, lagging grant by 1 cycle. valid stays 1.
- Early release: req=0101, done[0]=1 in the 2nd grant cycle of source 0 -> at that edge grant becomes 0100 and sel=010. Source 0 held the grant for 2 cycles. done[1]=1 while source 1 is not granted has no effect.
- Drop to idle: single owner 3 deasserts req, all other req=0 -> next edge grant=0000 and sel=100. One edge later c=0 and valid=0. A later req=0001 is granted after one edge.
- Reset mid-grant: reset=0 during the 3rd cycle of source 2's grant -> next edge clears all outputs. After release with req=1111, source 0 is granted first (pointer reset).

Source files
------------

// File: rtl/rr_channel_arbiter.sv
// rr_channel_arbiter
//   Round-robin arbiter sharing one registered W-bit channel among four
//   requesters. Each grant lasts at most HOLD cycles and can end early on
//   the owner's done bit or on the owner dropping req. The channel data c
//   and valid follow grant/sel by one cycle.
//
//   state | meaning
//   IDLE  | no owner; grant=0000, sel=100
//   GRANT | source sel[1:0] owns the channel; cnt holds remaining cycles-1
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   req[3:0]       request per source
//   done[3:0]      early release, honoured for the current owner only
//   b0..b3 [W-1:0] source data
//   grant[3:0]     one-hot owner, 0000 when idle
//   sel[2:0]       owner index 000..011, 100 when idle
//   c[W-1:0]       registered channel data
//   valid          c carries data from a granted source
module rr_channel_arbiter #(
  parameter int HOLD = 4,
  parameter int W    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [3:0]   done,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] b1,
  input  logic [W-1:0] b2,
  input  logic [W-1:0] b3,
  output logic [3:0]   grant,
  output logic [2:0]   sel,
  output logic [W-1:0] c,
  output logic         valid
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(HOLD - 1);
  localparam logic [2:0] SEL_IDLE   = 3'b100;

  state_t         state_q, state_d;
  logic [3:0]     grant_q, grant_d;
  logic [2:0]     sel_q, sel_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [1:0]     last_q, last_d;
  logic [W-1:0]   c_q, c_d;
  logic           valid_q, valid_d;

  logic [1:0]     owner;
  logic [1:0]     pick;
  logic           end_grant;
  logic [W-1:0]   owner_data;

  // First requester after the pointer, wrapping. Since last always equals
  // the current owner while granting, this also gives "start at k+1" on a
  // handover and lets k win again only if it is the sole requester.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign owner     = sel_q[1:0];
  assign pick      = rr_pick(req, last_q);
  assign end_grant = (cnt_q == 4'd0) || done[owner] || !req[owner];

  always_comb begin
    owner_data = b0;
    case (owner)
      2'd0: owner_data = b0;
      2'd1: owner_data = b1;
      2'd2: owner_data = b2;
      2'd3: owner_data = b3;
      default: owner_data = b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    c_d     = '0;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d = GRANT;
          grant_d = 4'b0001 << pick;
          sel_d   = {1'b0, pick};
          cnt_d   = CNT_RELOAD;
          last_d  = pick;
        end
      end
      GRANT: begin
        // data path samples the owner as it stands before this edge
        c_d     = owner_data;
        valid_d = 1'b1;
        if (end_grant) begin
          if (req != 4'b0000) begin
            grant_d = 4'b0001 << pick;
            sel_d   = {1'b0, pick};
            cnt_d   = CNT_RELOAD;
            last_d  = pick;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            sel_d   = SEL_IDLE;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        sel_d   = SEL_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= SEL_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 2'd3;
      c_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      c_q     <= c_d;
      valid_q <= valid_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign c     = c_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
module tb_rr_channel_arbiter;

  localparam int HOLD = 4;
  localparam int W    = 4;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [3:0]   done;
  logic [W-1:0] b0, b1, b2, b3;
  logic [3:0]   grant;
  logic [2:0]   sel;
  logic [W-1:0] c;
  logic         valid;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]   grant;
    logic [2:0]   sel;
    logic [W-1:0] c;
    logic         valid;
  } exp_t;

  exp_t exp_q[$];

  rr_channel_arbiter #(.HOLD(HOLD), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .done  (done),
    .b0    (b0),
    .b1    (b1),
    .b2    (b2),
    .b3    (b3),
    .grant (grant),
    .sel   (sel),
    .c     (c),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner (-1 = nobody), number of cycles the owner has
  // held the channel so far, and the index of the most recent grant.
  int           m_owner = -1;
  int           m_used  = 0;
  int           m_last  = 3;
  logic [W-1:0] m_c;
  logic         m_valid;
  logic [W-1:0] m_b [4];
  bit           m_found;
  int           m_idx;
  exp_t         m_e;

  always @(posedge clk) begin
    m_b[0] = b0; m_b[1] = b1; m_b[2] = b2; m_b[3] = b3;
    if (reset !== 1'b1) begin
      m_owner = -1;
      m_used  = 0;
      m_last  = 3;
      m_c     = '0;
      m_valid = 1'b0;
    end else begin
      m_c     = (m_owner >= 0) ? m_b[m_owner] : '0;
      m_valid = (m_owner >= 0);
      if (m_owner < 0 || m_used >= HOLD || done[m_owner] || !req[m_owner]) begin
        if (req != 4'b0000) begin
          m_found = 0;
          for (int s = 1; s <= 4; s++) begin
            m_idx = (m_last + s) % 4;
            if (!m_found && req[m_idx]) begin
              m_owner = m_idx;
              m_found = 1;
            end
          end
          m_last = m_owner;
          m_used = 1;
        end else begin
          m_owner = -1;
          m_used  = 0;
        end
      end else begin
        m_used = m_used + 1;
      end
    end
    m_e.grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    m_e.sel   = (m_owner >= 0) ? 3'(m_owner) : 3'b100;
    m_e.c     = m_c;
    m_e.valid = m_valid;
    exp_q.push_back(m_e);
  end

  // Monitor: compares DUT outputs away from the active edge.
  exp_t e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.grant || sel !== e.sel || c !== e.c || valid !== e.valid) begin
        errors++;
        $display("FAIL outputs t=%0t: got grant=%b sel=%b c=%h valid=%b, want grant=%b sel=%b c=%h valid=%b",
                 $time, grant, sel, c, valid, e.grant, e.sel, e.c, e.valid);
      end
      checks++;
      if (!((grant == 4'b0000 && sel == 3'b100) ||
            ($onehot(grant) && sel[2] == 1'b0 && grant == (4'b0001 << sel[1:0])))) begin
        errors++;
        $display("FAIL invariant t=%0t: got grant=%b sel=%b, want onehot grant matching sel or 0000/100",
                 $time, grant, sel);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0; req = 4'b1111; done = 4'b0000;
    b0 = 4'h5; b1 = 4'h0; b2 = 4'h0; b3 = 4'h0;

    // reset held with requests pending
    #1;
    step(3);
    reset = 1'b1;
    step(3);

    // single source re-granted back-to-back
    reset = 1'b0; step(1); reset = 1'b1;
    req = 4'b0010; b1 = 4'hA;
    step(12);

    // full contention
    reset = 1'b0; step(1); reset = 1'b1;
    req = 4'b1111; b0 = 4'h1; b1 = 4'h2; b2 = 4'h3; b3 = 4'h4;
    step(20);

    // early release of source 0 in its 2nd cycle; done[1] from a non-owner
    reset = 1'b0; step(1); reset = 1'b1;
    req = 4'b0101; done = 4'b0000;
    step(1);
    step(1);
    done = 4'b0011;
    step(1);
    done = 4'b0000;
    step(6);

    // single owner 3 drops to idle, then a fresh request
    req = 4'b1000; step(3);
    req = 4'b0000; step(3);
    req = 4'b0001; step(4);

    // reset in the 3rd cycle of source 2's grant
    req = 4'b0000; step(3);
    req = 4'b0100; b2 = 4'h7;
    step(1);
    step(2);
    reset = 1'b0; req = 4'b1111;
    step(1);
    reset = 1'b1;
    step(6);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      req   = 4'($urandom);
      done  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      b0    = 4'($urandom); b1 = 4'($urandom);
      b2    = 4'($urandom); b3 = 4'($urandom);
      reset = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) req = 4'b1111;
      step(1);
    end
    reset = 1'b1; req = 4'b0000; done = 4'b0000;
    step(3);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
